// File: rtl/pokey_audio_mixer.sv
// POKEY audio back end: resynchronises the four channel waveforms, sums the active volumes,
// latches the sum at a fixed sample rate and drives a first-order sigma-delta 1-bit output.
module pokey_audio_mixer #(
    parameter int unsigned SAMPLE_DIV = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       audio1,
    input  logic       audio2,
    input  logic       audio3,
    input  logic       audio4,
    input  logic [3:0] vol1,
    input  logic [3:0] vol2,
    input  logic [3:0] vol3,
    input  logic [3:0] vol4,
    input  logic       mute,
    output logic [5:0] level,
    output logic [5:0] sample_level,
    output logic       sample_valid,
    output logic       pdm_out
);

    localparam int unsigned CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

    if (SAMPLE_DIV < 2 || SAMPLE_DIV > 65535) begin : g_bad_div
        $error("pokey_audio_mixer: SAMPLE_DIV %0d outside 2..65535", SAMPLE_DIV);
    end

    logic [3:0]    a_m;
    logic [3:0]    a_s;
    logic [CW-1:0] cnt;
    logic [5:0]    acc;
    logic [5:0]    mix;

    always_comb begin
        mix = '0;
        mix = ({2'b00, a_s[0] ? vol1 : 4'd0} + {2'b00, a_s[1] ? vol2 : 4'd0})
            + ({2'b00, a_s[2] ? vol3 : 4'd0} + {2'b00, a_s[3] ? vol4 : 4'd0});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_m          <= '0;
            a_s          <= '0;
            level        <= '0;
            cnt          <= '0;
            sample_level <= '0;
            sample_valid <= 1'b0;
            acc          <= '0;
            pdm_out      <= 1'b0;
        end else begin
            a_m   <= {audio4, audio3, audio2, audio1};
            a_s   <= a_m;
            level <= mix;

            if (cnt == CNT_LAST) begin
                cnt          <= '0;
                sample_level <= mute ? 6'd0 : level;
                sample_valid <= 1'b1;
            end else begin
                cnt          <= cnt + 1'b1;
                sample_valid <= 1'b0;
            end

            // Carry out of the 6-bit accumulator is the pulse-density bit.
            {pdm_out, acc} <= {1'b0, acc} + {1'b0, sample_level};
        end
    end

endmodule
